// File: rtl/pio_cmd_responder_if.sv
// Bus bundle between the HPS PIO command responder and its surroundings:
// the PIO command/response words, the pixel-buffer port and the filter-engine
// control pair. The slave modport is the responder's view; the master modport
// is the view of whatever drives commands and answers memory reads.
interface pio_cmd_responder_if #(
  parameter int ADDR_W = 20
);
  logic [31:0]       pio_cmd;
  logic [31:0]       pio_rsp;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              mem_rvalid;
  logic              eng_start;
  logic              eng_busy;

  modport slave (
    input  pio_cmd, mem_rdata, mem_rvalid, eng_busy,
    output pio_rsp, mem_addr, mem_wdata, mem_we, mem_re, eng_start
  );

  modport master (
    output pio_cmd, mem_rdata, mem_rvalid, eng_busy,
    input  pio_rsp, mem_addr, mem_wdata, mem_we, mem_re, eng_start
  );
endinterface

// File: rtl/pio_cmd_responder.sv
// HPS PIO command responder. A command word arrives on an output PIO
// ([31] REQ, [30:28] OP, [27:8] ADDR, [7:0] WDATA) and is executed on a 0->1
// edge of the registered REQ bit: NOP, pixel WRITE, pixel READ, engine START
// or STATUS. The answer goes back on an input PIO ([31] ACK, [30] ERR,
// [29] BUSY, [7:0] RDATA) with a 4-phase REQ/ACK handshake.
// Optional feature macro: PIO_CMD_TIMEOUT_EN -- bounds the read wait to
// TIMEOUT_CYCLES cycles, answering ERR=1 and RDATA=8'hFF on expiry.
module pio_cmd_responder #(
  parameter int ADDR_W         = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  pio_cmd_responder_if.slave bus
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_READ   = 3'd2;
  localparam logic [2:0] OP_START  = 3'd3;
  localparam logic [2:0] OP_STATUS = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RD_WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;

  // Registered command word
  logic              req_p0;
  logic              req_prev;
  logic              req_edge;
  logic [2:0]        op_p0;
  logic [19:0]       addr_p0;
  logic [7:0]        wdata_p0;

  // Command latched on acceptance
  logic [2:0]        op_lat;
  logic [ADDR_W-1:0] addr_lat;
  logic [7:0]        wdata_lat;

  // Response fields
  logic              busy_p0;
  logic              err;
  logic [7:0]        rdata;
  logic              ack;

  // Decoded controls from the FSM
  logic              accept;
  logic              we;
  logic              re;
  logic              start;
  logic              err_set;
  logic              rdata_load;
  logic [7:0]        rdata_val;

  assign req_edge = req_p0 & ~req_prev;
  assign ack      = (state == RESP);

`ifdef PIO_CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in RD_WAIT; held at zero elsewhere so every entry starts fresh
  always_ff @(posedge clk) begin
    if (reset || state != RD_WAIT) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + CNT_W'(1);
  end
`else
  // No read-wait bound in this build: RD_WAIT waits for mem_rvalid forever and
  // TIMEOUT_CYCLES has no effect.
  if (TIMEOUT_CYCLES < 0) begin : g_no_timeout
  end
`endif

  // Stage p0: capture the command fields every cycle (data only, no reset)
  always_ff @(posedge clk) begin
    op_p0    <= bus.pio_cmd[30:28];
    addr_p0  <= bus.pio_cmd[27:8];
    wdata_p0 <= bus.pio_cmd[7:0];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and per-state strobes; a REQ edge only counts in IDLE
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    start      = 1'b0;
    err_set    = 1'b0;
    rdata_load = 1'b0;
    rdata_val  = 8'h00;
    case (state)
      IDLE: begin
        if (req_edge) begin
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
        case (op_lat)
          OP_NOP: ;
          OP_WRITE: we = 1'b1;
          OP_READ: begin
            re         = 1'b1;
            state_next = RD_WAIT;
          end
          OP_START: begin
            if (bus.eng_busy) err_set = 1'b1;
            else              start   = 1'b1;
          end
          OP_STATUS: begin
            rdata_load = 1'b1;
            rdata_val  = {7'd0, bus.eng_busy};
          end
          default: err_set = 1'b1;
        endcase
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_load = 1'b1;
          rdata_val  = bus.mem_rdata;
          state_next = RESP;
        end
`ifdef PIO_CMD_TIMEOUT_EN
        else if (tmo_hit) begin
          err_set    = 1'b1;
          rdata_load = 1'b1;
          rdata_val  = 8'hFF;
          state_next = RESP;
        end
`endif
      end
      RESP: begin
        if (!req_p0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // REQ edge detector, command latch and response fields; REQ history resets
  // high so a REQ held through reset is never taken as a new command
  always_ff @(posedge clk) begin
    if (reset) begin
      req_p0    <= 1'b1;
      req_prev  <= 1'b1;
      busy_p0   <= 1'b0;
      op_lat    <= OP_NOP;
      addr_lat  <= '0;
      wdata_lat <= 8'h00;
      err       <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      req_p0   <= bus.pio_cmd[31];
      req_prev <= req_p0;
      busy_p0  <= bus.eng_busy;
      if (accept) begin
        op_lat    <= op_p0;
        addr_lat  <= ADDR_W'(addr_p0);
        wdata_lat <= wdata_p0;
        err       <= 1'b0;
        rdata     <= 8'h00;
      end
      if (err_set)    err   <= 1'b1;
      if (rdata_load) rdata <= rdata_val;
    end
  end

  assign bus.mem_we    = we;
  assign bus.mem_re    = re;
  assign bus.eng_start = start;
  assign bus.mem_addr  = addr_lat;
  assign bus.mem_wdata = wdata_lat;
  assign bus.pio_rsp   = {ack, err, busy_p0, 21'd0, rdata};

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Testbench for pio_cmd_responder: directed handshake scenarios plus a
// randomized command stream checked against a behavioural response model.
module tb_pio_cmd_responder;

  localparam int ADDR_W = 20;
  localparam int TMO    = 8;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  int                obs_we, obs_re, obs_start, obs_overlap;
  int                obs_ack_lat, obs_drop_lat, obs_extra;
  logic [ADDR_W-1:0] obs_addr;
  logic [7:0]        obs_wdata;
  logic [31:0]       obs_rsp;

  always #5 clk = ~clk;

  pio_cmd_responder_if #(.ADDR_W(ADDR_W)) bus ();

  pio_cmd_responder #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Expected response word from the command rules
  function automatic logic [31:0] model_rsp(input logic [2:0] op, input logic busy,
                                            input logic [7:0] rv);
    logic       e;
    logic [7:0] rd;
    e  = (op > 3'd4) || (op == 3'd3 && busy);
    rd = (op == 3'd2) ? rv : (op == 3'd4) ? {7'd0, busy} : 8'd0;
    return {1'b1, e, busy, 21'd0, rd};
  endfunction

  function automatic int strobes();
    return int'(bus.mem_we) + int'(bus.mem_re) + int'(bus.eng_start);
  endfunction

  // Issue one command and watch until ACK or budget; answers a read d cycles
  // after mem_re (d <= 0: never answer)
  task automatic run_cmd(input logic [2:0] op, input logic [19:0] addr, input logic [7:0] wd,
                         input int d, input logic [7:0] rv, input int budget);
    int re_at;
    obs_we = 0; obs_re = 0; obs_start = 0; obs_overlap = 0;
    obs_ack_lat = -1; obs_rsp = 32'h0; obs_addr = '0; obs_wdata = 8'h00;
    re_at = -1;
    @(negedge clk);
    bus.pio_cmd   = {1'b1, op, addr, wd};
    bus.mem_rdata = ~rv;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = ~rv;
      if (bus.mem_we) begin obs_we++; obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata; end
      if (bus.mem_re) begin obs_re++; obs_addr = bus.mem_addr; re_at = n; end
      if (bus.eng_start) obs_start++;
      if (strobes() > 1) obs_overlap++;
      if (bus.pio_rsp[31]) begin
        obs_ack_lat = n;
        obs_rsp     = bus.pio_rsp;
        break;
      end
      if (re_at > 0 && d > 0 && n == re_at + d) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rv;
      end
    end
  endtask

  // Drop REQ and count cycles until ACK falls
  task automatic drop_req(input int budget);
    obs_drop_lat = -1;
    obs_extra    = 0;
    bus.pio_cmd[31] = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      obs_extra += strobes();
      if (!bus.pio_rsp[31]) begin
        obs_drop_lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.pio_cmd = 32'h0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00; bus.eng_busy = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pio_rsp !== 32'h0) begin
      errors++; $display("FAIL reset_rsp got %h want 00000000", bus.pio_rsp);
    end
    checks++;
    if ({bus.mem_we, bus.mem_re, bus.eng_start} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes got %b want 000", {bus.mem_we, bus.mem_re, bus.eng_start});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_addr_data got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata);
    end
    bus.eng_busy = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_cmd(3'd1, 20'h0002A, 8'h5C, 0, 8'h00, 20);
    checks++;
    if (obs_we != 1 || obs_re != 0 || obs_start != 0) begin
      errors++; $display("FAIL write_strobes we=%0d re=%0d start=%0d want 1/0/0", obs_we, obs_re, obs_start);
    end
    checks++;
    if (obs_addr !== 20'h0002A || obs_wdata !== 8'h5C) begin
      errors++; $display("FAIL write_addr_data got %h/%h want 0002a/5c", obs_addr, obs_wdata);
    end
    checks++;
    if (obs_ack_lat != 3 || obs_rsp !== 32'h8000_0000) begin
      errors++; $display("FAIL write_ack lat=%0d rsp=%h want 3/80000000", obs_ack_lat, obs_rsp);
    end
    drop_req(6);
    checks++;
    if (obs_drop_lat < 1 || obs_drop_lat > 2) begin
      errors++; $display("FAIL write_ack_fall lat=%0d want 1..2", obs_drop_lat);
    end
  endtask

  task automatic test_read();
    run_cmd(3'd2, 20'h00001, 8'h00, 4, 8'h7E, 20);
    checks++;
    if (obs_re != 1 || obs_we != 0 || obs_addr !== 20'h00001) begin
      errors++; $display("FAIL read_strobe re=%0d we=%0d addr=%h want 1/0/00001", obs_re, obs_we, obs_addr);
    end
    checks++;
    if (obs_ack_lat != 7 || obs_rsp !== 32'h8000_007E) begin
      errors++; $display("FAIL read_ack lat=%0d rsp=%h want 7/8000007e", obs_ack_lat, obs_rsp);
    end
    drop_req(6);
  endtask

  task automatic test_start();
    bus.eng_busy = 1'b0;
    run_cmd(3'd3, 20'h0, 8'h00, 0, 8'h00, 20);
    checks++;
    if (obs_start != 1 || obs_rsp !== 32'h8000_0000) begin
      errors++; $display("FAIL start_idle pulses=%0d rsp=%h want 1/80000000", obs_start, obs_rsp);
    end
    drop_req(6);
    bus.eng_busy = 1'b1;
    run_cmd(3'd3, 20'h0, 8'h00, 0, 8'h00, 20);
    checks++;
    if (obs_start != 0 || obs_rsp !== 32'hE000_0000) begin
      errors++; $display("FAIL start_busy pulses=%0d rsp=%h want 0/e0000000", obs_start, obs_rsp);
    end
    drop_req(6);
  endtask

  task automatic test_status();
    bus.eng_busy = 1'b1;
    run_cmd(3'd4, 20'h0, 8'h00, 0, 8'h00, 20);
    checks++;
    if (obs_rsp !== 32'hA000_0001) begin
      errors++; $display("FAIL status_busy rsp=%h want a0000001", obs_rsp);
    end
    drop_req(6);
    bus.eng_busy = 1'b0;
    run_cmd(3'd4, 20'h0, 8'h00, 0, 8'h00, 20);
    checks++;
    if (obs_rsp !== 32'h8000_0000) begin
      errors++; $display("FAIL status_idle rsp=%h want 80000000", obs_rsp);
    end
    drop_req(6);
  endtask

  task automatic test_illegal();
    int bad;
    run_cmd(3'd7, 20'h0, 8'h00, 0, 8'h00, 20);
    checks++;
    if (obs_we + obs_re + obs_start != 0 || obs_rsp !== 32'hC000_0000) begin
      errors++; $display("FAIL illegal got strobes=%0d rsp=%h want 0/c0000000", obs_we + obs_re + obs_start, obs_rsp);
    end
    bus.pio_cmd = 32'h9000_0055;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      bad += strobes();
      if (!bus.pio_rsp[31]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL illegal_hold got %0d anomalies want 0", bad);
    end
    drop_req(6);
  endtask

  task automatic test_edge_in_rdwait();
    int bad;
    run_cmd(3'd2, 20'h0ABCD, 8'h00, 0, 8'h00, 5);
    checks++;
    if (obs_re != 1 || obs_ack_lat != -1) begin
      errors++; $display("FAIL rdwait_entry re=%0d lat=%0d want 1/-1", obs_re, obs_ack_lat);
    end
    bus.pio_cmd[31] = 1'b0;
    @(negedge clk);
    bus.pio_cmd = 32'h9001_2345;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      bad += strobes();
      if (bus.pio_rsp[31]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rdwait_edge_ignored got %0d anomalies want 0", bad);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'h3C;
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00;
    checks++;
    if (bus.pio_rsp !== 32'h8000_003C) begin
      errors++; $display("FAIL rdwait_resp got %h want 8000003c", bus.pio_rsp);
    end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      bad += strobes();
      if (bus.pio_rsp !== 32'h8000_003C) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL resp_hold got %0d anomalies want 0", bad);
    end
    drop_req(6);
  endtask

  task automatic test_req_held_reset();
    int bad;
    @(negedge clk);
    bus.pio_cmd = 32'h9000_1234;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      bad += strobes();
      if (bus.pio_rsp[31]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL held_req_after_reset got %0d anomalies want 0", bad);
    end
    bus.pio_cmd[31] = 1'b0;
    repeat (2) @(negedge clk);
    run_cmd(3'd1, 20'h00012, 8'h34, 0, 8'h00, 20);
    checks++;
    if (obs_we != 1 || obs_ack_lat != 3 || obs_addr !== 20'h00012) begin
      errors++; $display("FAIL held_req_retry we=%0d lat=%0d addr=%h want 1/3/00012", obs_we, obs_ack_lat, obs_addr);
    end
    drop_req(6);
  endtask

  task automatic test_reset_during_read();
    int bad;
    run_cmd(3'd2, 20'h00777, 8'h00, 0, 8'h00, 5);
    reset = 1'b1;
    bus.pio_cmd = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 8'hA5;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      bad += strobes();
      if (bus.pio_rsp !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL late_rvalid_after_reset got %0d anomalies want 0", bad);
    end
    run_cmd(3'd1, 20'h00321, 8'h99, 0, 8'h00, 20);
    checks++;
    if (obs_we != 1 || obs_ack_lat != 3 || obs_rsp !== 32'h8000_0000) begin
      errors++; $display("FAIL post_reset_write we=%0d lat=%0d rsp=%h want 1/3/80000000", obs_we, obs_ack_lat, obs_rsp);
    end
    drop_req(6);
  endtask

  task automatic test_read_timeout();
`ifdef PIO_CMD_TIMEOUT_EN
    run_cmd(3'd2, 20'h00042, 8'h00, 0, 8'h00, 40);
    checks++;
    if (obs_re != 1 || obs_ack_lat != 3 + TMO || obs_rsp !== 32'hC000_00FF) begin
      errors++; $display("FAIL read_timeout re=%0d lat=%0d rsp=%h want 1/%0d/c00000ff", obs_re, obs_ack_lat, obs_rsp, 3 + TMO);
    end
    drop_req(6);
`else
    run_cmd(3'd2, 20'h00042, 8'h00, 0, 8'h00, 1000);
    checks++;
    if (obs_re != 1 || obs_ack_lat != -1) begin
      errors++; $display("FAIL read_no_timeout re=%0d lat=%0d want 1/-1", obs_re, obs_ack_lat);
    end
    reset = 1'b1;
    bus.pio_cmd = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pio_rsp !== 32'h0) begin
      errors++; $display("FAIL read_abandon_rsp got %h want 00000000", bus.pio_rsp);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [19:0] addr;
    logic [7:0]  wd, rv;
    logic        busy;
    int          d, exp_lat;
    logic [31:0] exp_rsp;
    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = 20'($urandom);
      wd   = 8'($urandom);
      rv   = 8'($urandom);
      busy = 1'($urandom_range(0, 1));
      d    = int'($urandom_range(1, 6));
      bus.eng_busy = busy;
      run_cmd(op, addr, wd, d, rv, 30);
      exp_rsp = model_rsp(op, busy, rv);
      exp_lat = (op == 3'd2) ? 3 + d : 3;
      checks++;
      if (obs_ack_lat != exp_lat || obs_rsp !== exp_rsp) begin
        errors++; $display("FAIL rand%0d_rsp op=%0d lat=%0d rsp=%h want %0d/%h", i, op, obs_ack_lat, obs_rsp, exp_lat, exp_rsp);
      end
      checks++;
      if (obs_we != int'(op == 3'd1) || obs_re != int'(op == 3'd2) ||
          obs_start != int'(op == 3'd3 && !busy) || obs_overlap != 0) begin
        errors++; $display("FAIL rand%0d_strobes op=%0d we=%0d re=%0d start=%0d ovl=%0d want %0d/%0d/%0d/0", i, op,
                           obs_we, obs_re, obs_start, obs_overlap, int'(op == 3'd1), int'(op == 3'd2), int'(op == 3'd3 && !busy));
      end
      if (op == 3'd1 || op == 3'd2) begin
        checks++;
        if (obs_addr !== addr || (op == 3'd1 && obs_wdata !== wd)) begin
          errors++; $display("FAIL rand%0d_addr_data got %h/%h want %h/%h", i, obs_addr, obs_wdata, addr, wd);
        end
      end
      drop_req(6);
      checks++;
      if (obs_drop_lat < 1 || obs_drop_lat > 2 || obs_extra != 0) begin
        errors++; $display("FAIL rand%0d_ack_fall lat=%0d extra=%0d want 1..2/0", i, obs_drop_lat, obs_extra);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.pio_cmd = 32'h0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00; bus.eng_busy = 1'b0;
    test_reset();
    test_write();
    test_reset();
    test_read();
    test_start();
    test_status();
    test_illegal();
    test_edge_in_rdwait();
    test_req_held_reset();
    test_reset_during_read();
    test_read_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
